// File: rtl/ram_bank.sv
// Single-port synchronous RAM bank with byte strobes, valid/ready requests,
// 1-cycle registered response, range checking and a post-reset clear sequence.
module ram_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   data_i,
  output logic                rsp_valid_o,
  output logic [DATA_W-1:0]   data_o,
  output logic                err_o,
  output logic                init_done_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = DATA_W / 8;

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [AW-1:0]     clr_ptr;
  logic [AW-1:0]     clr_ptr_nxt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              in_range;
  logic [AW-1:0]     idx;
  logic [DATA_W-1:0] cur;
  logic [DATA_W-1:0] merged;

  assign accept   = req_valid_i & req_ready_o;
  assign in_range = addr_i < ADDR_W'(DEPTH);
  assign idx      = addr_i[AW-1:0];
  assign cur      = mem[idx];

  always_comb begin
    merged = cur;
    for (int n = 0; n < NB; n++) begin
      if (be_i[n]) merged[8*n +: 8] = data_i[8*n +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    req_ready_o = 1'b0;
    init_done_o = 1'b0;
    unique case (state)
      CLEAR: begin
        clr_ptr_nxt = clr_ptr + 1'b1;
        if (clr_ptr == AW'(DEPTH - 1)) state_nxt = READY;
      end
      READY: begin
        req_ready_o = 1'b1;
        init_done_o = 1'b1;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // The clear pointer owns the single port until the sequence completes.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_ptr] <= '0;
    end else if (accept && we_i && in_range) begin
      mem[idx] <= merged;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rsp_valid_o <= 1'b0;
      err_o       <= 1'b0;
      data_o      <= '0;
    end else begin
      rsp_valid_o <= accept;
      err_o       <= accept & ~in_range;
      if (accept) begin
        if (!in_range) data_o <= '0;
        else if (we_i) data_o <= merged;
        else           data_o <= cur;
      end
    end
  end

endmodule
